// File: rtl/button_event_decoder.sv
// Purpose : classify a clean, synchronous button level into one-cycle event pulses
//           (press, release, short press, long press, auto-repeat, double click).
// Latency : every pulse is registered on the same edge that samples the causing input
//           edge or timer expiry; held lags debounced_btn by one cycle.
// Backpressure: none; the decoder always accepts the input level and pulses are fire-and-forget.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   negated_reset  asynchronous active-low reset
//   debounced_btn  debounced button level, already synchronous to clk
//   held           registered copy of debounced_btn
//   press_pulse    rising edge seen
//   release_pulse  falling edge seen
//   short_press    single press released before the long count, no second press in the window
//   long_press     hold reached LONG_CYCLES
//   repeat_pulse   every REPEAT_CYCLES after long_press while still held
//   double_click   second press landed inside the window
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic negated_reset,
    input  logic debounced_btn,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT      = 3'd3,
        S_SECOND    = 3'd4
    } state_t;

    // The timer is cleared on the edge that enters a state, so on the edge that is
    // N cycles later it reads N-1; compares therefore use the constant minus one.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             btn_prev;
    logic             rise;
    logic             fall;

    assign rise = debounced_btn & ~btn_prev;
    assign fall = ~debounced_btn & btn_prev;
    assign held = btn_prev;

    // Saturate instead of wrapping: states with no timeout (IDLE, SECOND) can sit
    // indefinitely and must never see a spurious match after a wrap.
    assign timer_nxt = (&timer) ? timer : timer + 1'b1;

    // Input edges are tested before timer expiry in every state, which gives the
    // required priority when both happen on the same edge.
    always_ff @(posedge clk or negedge negated_reset) begin
        if (!negated_reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            btn_prev      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            btn_prev      <= debounced_btn;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            timer         <= timer_nxt;

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state       <= S_PRESSED;
                        timer       <= '0;
                        press_pulse <= 1'b1;
                    end
                end

                S_PRESSED: begin
                    if (fall) begin
                        state         <= S_WAIT;
                        timer         <= '0;
                        release_pulse <= 1'b1;
                    end else if (timer == LONG_LAST) begin
                        state      <= S_LONG_HELD;
                        timer      <= '0;
                        long_press <= 1'b1;
                    end
                end

                S_LONG_HELD: begin
                    if (fall) begin
                        state         <= S_IDLE;
                        timer         <= '0;
                        release_pulse <= 1'b1;
                    end else if (timer == REPEAT_LAST) begin
                        // Restart the period without leaving the state.
                        timer        <= '0;
                        repeat_pulse <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (rise) begin
                        state        <= S_SECOND;
                        timer        <= '0;
                        press_pulse  <= 1'b1;
                        double_click <= 1'b1;
                    end else if (timer == WINDOW_LAST) begin
                        state       <= S_IDLE;
                        timer       <= '0;
                        short_press <= 1'b1;
                    end
                end

                S_SECOND: begin
                    // A second press never escalates to long press or repeat.
                    if (fall) begin
                        state         <= S_IDLE;
                        timer         <= '0;
                        release_pulse <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios with absolute edge expectations
// plus a randomized level sequence checked edge-by-edge against a timestamp-based model.
module tb_button_event_decoder;

    localparam int LONG_C = 8;
    localparam int WIN_C  = 6;
    localparam int REP_C  = 4;
    localparam int CW     = 4;

    logic clk = 1'b0;
    logic negated_reset;
    logic debounced_btn;
    logic held, press_pulse, release_pulse, short_press, long_press, repeat_pulse, double_click;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_CYCLES  (LONG_C),
        .WINDOW_CYCLES(WIN_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .negated_reset(negated_reset),
        .debounced_btn(debounced_btn),
        .held         (held),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .double_click (double_click)
    );

    // Event bit positions used in logs and expectations.
    localparam logic [5:0] E_PRESS = 6'b000001;
    localparam logic [5:0] E_REL   = 6'b000010;
    localparam logic [5:0] E_SHORT = 6'b000100;
    localparam logic [5:0] E_LONG  = 6'b001000;
    localparam logic [5:0] E_REP   = 6'b010000;
    localparam logic [5:0] E_DBL   = 6'b100000;

    int checks = 0;
    int errors = 0;

    // Reference model: phases named after the button's life cycle, timing by timestamps.
    localparam int PH_IDLE = 0, PH_DOWN = 1, PH_LONG = 2, PH_GAP = 3, PH_DOWN2 = 4;
    int   m_phase;
    int   m_mark;      // edge at which the current phase began
    bit   m_prev;
    int   k_abs  = 0;
    int   edge_n = 0;
    logic [5:0] ev_log [0:63];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    function automatic logic [7:0] outs();
        return {1'b0, held, double_click, repeat_pulse, long_press,
                short_press, release_pulse, press_pulse};
    endfunction

    function automatic int pulse_total(input int last);
        int n = 0;
        for (int i = 1; i <= last; i++)
            for (int b = 0; b < 6; b++)
                n += int'(ev_log[i][b]);
        return n;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_prev  = 1'b0;
        m_mark  = 0;
    endtask

    // Drive a level, let one edge sample it, compare against the model.
    task automatic step(input bit b, input string tag);
        logic [5:0] ev;
        bit rise, fall;
        debounced_btn = b;
        @(posedge clk);
        #1;
        k_abs++;
        edge_n++;
        rise = b & ~m_prev;
        fall = ~b & m_prev;
        ev   = '0;
        case (m_phase)
            PH_IDLE:  if (rise) begin ev = E_PRESS; m_phase = PH_DOWN; m_mark = k_abs; end
            PH_DOWN:  if (fall) begin ev = E_REL; m_phase = PH_GAP; m_mark = k_abs; end
                      else if (k_abs - m_mark == LONG_C) begin
                          ev = E_LONG; m_phase = PH_LONG; m_mark = k_abs;
                      end
            PH_LONG:  if (fall) begin ev = E_REL; m_phase = PH_IDLE; end
                      else if ((k_abs - m_mark) % REP_C == 0) ev = E_REP;
            PH_GAP:   if (rise) begin ev = E_PRESS | E_DBL; m_phase = PH_DOWN2; end
                      else if (k_abs - m_mark == WIN_C) begin ev = E_SHORT; m_phase = PH_IDLE; end
            PH_DOWN2: if (fall) begin ev = E_REL; m_phase = PH_IDLE; end
            default:  m_phase = PH_IDLE;
        endcase
        m_prev = b;
        chk(tag, outs(), {1'b0, logic'(b), ev});
        if (edge_n < 64) ev_log[edge_n] = outs() & 8'h3f;
    endtask

    task automatic seg(input bit b, input int until_edge, input string tag);
        while (edge_n < until_edge) step(b, tag);
    endtask

    // Reset with the given button level, hold over one clock edge, release at a negedge.
    task automatic start_scn(input bit b, input string tag);
        debounced_btn = b;
        negated_reset = 1'b0;
        #1;
        chk({tag, ".rst"}, outs(), 8'h00);
        @(posedge clk);
        #1;
        chk({tag, ".rst_edge"}, outs(), 8'h00);
        model_reset();
        for (int i = 0; i < 64; i++) ev_log[i] = '0;
        edge_n = 0;
        @(negedge clk);
        negated_reset = 1'b1;
    endtask

    initial begin
        negated_reset = 1'b1;
        debounced_btn = 1'b0;
        model_reset();

        // Short press
        start_scn(1'b0, "short");
        seg(0, 9, "short"); seg(1, 12, "short"); seg(0, 30, "short");
        chk("short.p10", {2'b0, ev_log[10]}, {2'b0, E_PRESS});
        chk("short.r13", {2'b0, ev_log[13]}, {2'b0, E_REL});
        chk("short.s19", {2'b0, ev_log[19]}, {2'b0, E_SHORT});
        chk("short.total", 8'(pulse_total(30)), 8'd3);

        // Long press with repeats
        start_scn(1'b0, "long");
        seg(0, 9, "long"); seg(1, 26, "long"); seg(0, 40, "long");
        chk("long.p10", {2'b0, ev_log[10]}, {2'b0, E_PRESS});
        chk("long.l18", {2'b0, ev_log[18]}, {2'b0, E_LONG});
        chk("long.rp22", {2'b0, ev_log[22]}, {2'b0, E_REP});
        chk("long.rp26", {2'b0, ev_log[26]}, {2'b0, E_REP});
        chk("long.r27", {2'b0, ev_log[27]}, {2'b0, E_REL});
        chk("long.total", 8'(pulse_total(40)), 8'd5);

        // Double click, second press at the last edge of the window
        start_scn(1'b0, "dbl");
        seg(0, 9, "dbl"); seg(1, 12, "dbl"); seg(0, 18, "dbl"); seg(1, 39, "dbl"); seg(0, 50, "dbl");
        chk("dbl.p10", {2'b0, ev_log[10]}, {2'b0, E_PRESS});
        chk("dbl.d19", {2'b0, ev_log[19]}, {2'b0, E_PRESS | E_DBL});
        chk("dbl.r40", {2'b0, ev_log[40]}, {2'b0, E_REL});
        chk("dbl.total", 8'(pulse_total(50)), 8'd5);

        // Release on the edge the long count is reached
        start_scn(1'b0, "bnd1");
        seg(0, 9, "bnd1"); seg(1, 17, "bnd1"); seg(0, 30, "bnd1");
        chk("bnd1.r18", {2'b0, ev_log[18]}, {2'b0, E_REL});
        chk("bnd1.s24", {2'b0, ev_log[24]}, {2'b0, E_SHORT});
        chk("bnd1.total", 8'(pulse_total(30)), 8'd3);

        // Second press one edge after the window closed
        start_scn(1'b0, "bnd2");
        seg(0, 9, "bnd2"); seg(1, 17, "bnd2"); seg(0, 24, "bnd2"); seg(1, 27, "bnd2"); seg(0, 30, "bnd2");
        chk("bnd2.s24", {2'b0, ev_log[24]}, {2'b0, E_SHORT});
        chk("bnd2.p25", {2'b0, ev_log[25]}, {2'b0, E_PRESS});

        // Async reset during a pulse clears outputs with no clock edge
        start_scn(1'b0, "arst_a");
        seg(0, 9, "arst_a"); seg(1, 10, "arst_a");
        negated_reset = 1'b0;
        #2;
        chk("arst_a.immediate", outs(), 8'h00);
        @(negedge clk);
        debounced_btn = 1'b0;
        negated_reset = 1'b1;
        model_reset();

        // Async reset between edges 14 and 15 aborts the pending short press
        start_scn(1'b0, "arst_b");
        seg(0, 9, "arst_b"); seg(1, 11, "arst_b"); seg(0, 14, "arst_b");
        negated_reset = 1'b0;
        #2;
        chk("arst_b.immediate", outs(), 8'h00);
        @(negedge clk);
        negated_reset = 1'b1;
        model_reset();
        seg(0, 30, "arst_b");
        chk("arst_b.no_s18", {2'b0, ev_log[18]}, 8'h00);

        // Button held through reset release is a fresh press
        start_scn(1'b1, "arst_c");
        step(1, "arst_c");
        chk("arst_c.p1", {2'b0, ev_log[1]}, {2'b0, E_PRESS});

        // Randomized level sequence
        start_scn(1'b0, "rand");
        begin
            bit lvl = 1'b0;
            for (int s = 0; s < 80; s++) begin
                int len = int'($urandom_range(1, 14));
                lvl = ~lvl;
                for (int i = 0; i < len; i++) step(lvl, "rand");
            end
            for (int i = 0; i < 20; i++) step(0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the clean, synchronous button level from the debounce stage into single-cycle event pulses: press, release, short press, long press, auto-repeat while held, and double click. It sits directly downstream of the debouncer and feeds the control FSMs and counters in the lab top levels, so they never handle raw levels or timing.

## Interface
- LONG_CYCLES, 50_000_000: hold duration, in clk cycles, that qualifies as a long press; must be ≥2.
- WINDOW_CYCLES, 25_000_000: double-click window after a short release, in cycles; must be ≥2.
- REPEAT_CYCLES, 10_000_000: auto-repeat period while long-held; must be ≥2.
- CNT_W, 27: timer width; must hold max(LONG_CYCLES, WINDOW_CYCLES, REPEAT_CYCLES).
- clk  input  1  system clock; all logic is on posedge.
- negated_reset  input  1  asynchronous, active-low reset.
- debounced_btn  input  1  debounced level, already synchronous to clk.
- held  output  1  registered copy of debounced_btn.
- press_pulse  output  1  one-cycle pulse on each sampled rising edge.
- release_pulse  output  1  one-cycle pulse on each sampled falling edge.
- short_press  output  1  one-cycle pulse when a single press is released before LONG_CYCLES and no second press follows within the window.
- long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while still held.
- double_click  output  1  one-cycle pulse on the second press inside the window.

## Operation
- btn_prev register stores the last sampled value and drives held. rise = debounced_btn & ~btn_prev. fall = ~debounced_btn & btn_prev.
- One shared CNT_W-bit timer. It clears on every state change and increments once per cycle otherwise. Its compares use the constant minus 1 in CNT_W-bit arithmetic. It never wraps.
- States and transitions:
  - IDLE: rise → PRESSED, press_pulse.
  - PRESSED: fall → WAIT, release_pulse. Else, timer reaching the long count → LONG_HELD, long_press.
  - LONG_HELD: fall → IDLE, release_pulse, no short_press. Else repeat_pulse each time the timer reaches the repeat count; the timer then clears.
  - WAIT: rise → SECOND, press_pulse + double_click. Else, timer reaching the window count → IDLE, short_press.
  - SECOND: fall → IDLE, release_pulse. No long press or repeat is generated from a second press.
- Simultaneous events: input edges take priority over timer expiry in every state.
  - A fall in the same cycle the long count is reached gives no long_press; the FSM goes to WAIT.
  - A rise in the same cycle the window expires gives double_click, not short_press.
- All pulse outputs are registered and are never asserted for two consecutive cycles from the same event.

## Timing
- Reset (negated_reset low, asynchronous): state IDLE, timer 0, btn_prev 0, all outputs 0 immediately. No pulses while reset is held.
- Reset mid-operation aborts any pending event; no short_press or double_click is produced afterwards.
- A button held through reset release is seen as a rise on the first sampled edge, so press_pulse fires.
- Latency: for input sampled 1 at edge k (0 at edge k-1), press_pulse is high from edge k to k+1. Every other event has the same 1-edge latency from the sampling edge.
- Long press: for a press at edge k still held, long_press fires at edge k+LONG_CYCLES. repeat_pulse fires at k+LONG_CYCLES+n·REPEAT_CYCLES for n≥1.
- Window: for a release at edge m, a rise sampled at edges m+1 through m+WINDOW_CYCLES gives double_click. Otherwise short_press fires at edge m+WINDOW_CYCLES.
- held follows debounced_btn with 1 cycle of delay.

## Test plan
Bench parameters: LONG_CYCLES=8, WINDOW_CYCLES=6, REPEAT_CYCLES=4, CNT_W=4.
- Short press: high at edge 10, low at edge 13 → press_pulse@10, release_pulse@13, short_press@19, no other pulses.
- Long press: high at edge 10, low at edge 27 → press_pulse@10, long_press@18, repeat_pulse@22 and @26, release_pulse@27, no short_press.
- Double click: high 10–12, low at 13, high at 19, low at 40 → double_click@19, press_pulse@10 and @19, no short_press, no long_press, release_pulse@40.
- Boundaries: release exactly at edge 18 after a press at 10 → no long_press, short_press@24. Second press at 25 (window missed) → short_press@24, then a fresh press_pulse@25 with no double_click.
- Async reset: press at 10, release at 12, negated_reset low between edges 14 and 15 → all outputs 0 with no clock edge, no short_press@18. Reset released with button high → press_pulse on the first sampling edge.
